// File: rtl/data_mux_pkg.sv
// Shared types and constants for the data_mux_fsm time-division multiplexer.
package data_mux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_DS1 = 2'd1,
    S_DS2 = 2'd2,
    S_DS3 = 2'd3
  } state_t;

  localparam logic [2:0] MODE_DS1   = 3'd1;
  localparam logic [2:0] MODE_DS12  = 3'd2;
  localparam logic [2:0] MODE_DS123 = 3'd3;

  // Modes 1..3 select streams; everything else forces a zero output.
  function automatic logic mode_active(input logic [2:0] m);
    return (m == MODE_DS1) || (m == MODE_DS12) || (m == MODE_DS123);
  endfunction

endpackage

// File: rtl/symbol_edge_detect.sv
// Symbol strobe rising-edge detector.
// Default: 2-flop synchronizer then edge detect (sym_edge after 2 clk edges,
// so the symbol is captured on the 3rd edge).
// DATA_MUX_SYNC_BYPASS_EN: symbol_clk is already clk-synchronous, so the
// synchronizer is dropped and the symbol is captured on the 1st edge.
module symbol_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic symbol_clk,
  output logic sym_edge
);

`ifdef DATA_MUX_SYNC_BYPASS_EN
  logic s3;

  // Remember the previous strobe level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s3 <= 1'b0;
    else      s3 <= symbol_clk;
  end

  assign sym_edge = symbol_clk & ~s3;
`else
  logic s1, s2, s3;

  // Two-flop synchronizer followed by a delay stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= symbol_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sym_edge = s2 & ~s3;
`endif

endmodule

// File: rtl/data_mux_fsm.sv
// Time-division multiplexer: captures up to three streams on each symbol edge
// and steps output_data through the active ones every switch_clk_cycles clks.
// Optional macro: DATA_MUX_SYNC_BYPASS_EN (removes the symbol synchronizer).
// Handshake note: there is no valid/ready; symbol_clk is a level strobe whose
// rising edge is the only event, and output_data is valid every cycle.
module data_mux_fsm
  import data_mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              symbol_clk,
  input  logic [2:0]        mode,
  input  logic [CNT_W-1:0]  switch_clk_cycles,
  input  logic [DATA_W-1:0] DS1,
  input  logic [DATA_W-1:0] DS2,
  input  logic [DATA_W-1:0] DS3,
  output logic [DATA_W-1:0] output_data,
  output logic [1:0]        state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cap_switch;
  logic [2:0]        cap_mode;
  logic [DATA_W-1:0] cap_ds1, cap_ds2, cap_ds3;
  logic              sym_edge;
  logic              slot_done;

  symbol_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .symbol_clk (symbol_clk),
    .sym_edge   (sym_edge)
  );

  // A switch count of 0 means "never switch"; the guard also keeps a
  // saturated counter from matching 0-1 = all ones.
  assign slot_done = (cap_switch != '0) && (cnt == (cap_switch - CNT_ONE));
  assign cnt_inc   = (&cnt) ? cnt : (cnt + CNT_ONE);
  assign state_dbg = state;

  // Shadow capture, slot counter, FSM and registered output in one block;
  // the symbol edge takes priority over any slot transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_switch  <= '0;
      cap_mode    <= 3'd0;
      cap_ds1     <= '0;
      cap_ds2     <= '0;
      cap_ds3     <= '0;
      output_data <= '0;
    end else if (sym_edge) begin
      cap_switch <= switch_clk_cycles;
      cap_mode   <= mode;
      cap_ds1    <= DS1;
      cap_ds2    <= DS2;
      cap_ds3    <= DS3;
      cnt        <= '0;
      if (mode_active(mode)) begin
        state       <= S_DS1;
        output_data <= DS1;
      end else begin
        state       <= IDLE;
        output_data <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          output_data <= '0;
        end
        S_DS1: begin
          if (slot_done && (cap_mode == MODE_DS12 || cap_mode == MODE_DS123)) begin
            state       <= S_DS2;
            cnt         <= '0;
            output_data <= cap_ds2;
          end else begin
            cnt         <= cnt_inc;
            output_data <= cap_ds1;
          end
        end
        S_DS2: begin
          if (slot_done) begin
            cnt <= '0;
            if (cap_mode == MODE_DS123) begin
              state       <= S_DS3;
              output_data <= cap_ds3;
            end else begin
              state       <= S_DS1;
              output_data <= cap_ds1;
            end
          end else begin
            cnt         <= cnt_inc;
            output_data <= cap_ds2;
          end
        end
        S_DS3: begin
          if (slot_done) begin
            state       <= S_DS1;
            cnt         <= '0;
            output_data <= cap_ds1;
          end else begin
            cnt         <= cnt_inc;
            output_data <= cap_ds3;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          output_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mux_fsm.sv
// Bench for data_mux_fsm: symbol-level driver, expected-value queue filled at
// the capture edge from a slot-index model, per-cycle output monitor.
module tb_data_mux_fsm;

  localparam int DW = 32;
  localparam int CW = 32;

`ifdef DATA_MUX_SYNC_BYPASS_EN
  localparam int CAP_C = 0;  // symbol captured on 1st edge after rise
`else
  localparam int CAP_C = 2;  // symbol captured on 3rd edge after rise
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          symbol_clk;
  logic [2:0]    mode;
  logic [CW-1:0] switch_clk_cycles;
  logic [DW-1:0] ds1, ds2, ds3;
  logic [DW-1:0] output_data;
  logic [1:0]    state_dbg;

  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  string         cur_tag = "init";

  data_mux_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .symbol_clk        (symbol_clk),
    .mode              (mode),
    .switch_clk_cycles (switch_clk_cycles),
    .DS1               (ds1),
    .DS2               (ds2),
    .DS3               (ds3),
    .output_data       (output_data),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected output k clks after the capture edge, from the slot index.
  function automatic logic [DW-1:0] exp_val(input logic [2:0] m, input logic [CW-1:0] sw,
                                            input int k, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] c);
    int idx;
    if (m < 3'd1 || m > 3'd3) return '0;
    if (m == 3'd1 || sw == 0) return a;
    idx = (k / int'(sw)) % int'(m);
    case (idx)
      0:       return a;
      1:       return b;
      default: return c;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check(cur_tag, output_data, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Drive nsym symbols of 'period' clks; optionally change DS2 mid-symbol 0.
  task automatic run_phase(input string tag, input logic [2:0] m, input logic [CW-1:0] sw,
                           input int period, input int nsym,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input bit mid_chg,
                           input logic [DW-1:0] b_new, input bit do_drain);
    for (int s = 0; s < nsym; s++) begin
      for (int cy = 0; cy < period; cy++) begin
        @(negedge clk);
        symbol_clk = (cy < period / 2);
        if (s == 0 && cy == 0) begin
          cur_tag = tag;
          mode = m;
          switch_clk_cycles = sw;
          ds1 = a;
          ds2 = b;
          ds3 = c;
        end
        if (mid_chg && s == 0 && cy == 5) ds2 = b_new;
        if (cy == CAP_C)
          for (int k = 0; k < period; k++)
            exp_q.push_back(exp_val(mode, switch_clk_cycles, k, ds1, ds2, ds3));
      end
    end
    if (do_drain) begin
      @(negedge clk);
      symbol_clk = 1'b0;
      drain();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    symbol_clk = 1'b0;
    mode = 3'd0;
    switch_clk_cycles = '0;
    ds1 = '0;
    ds2 = '0;
    ds3 = '0;
    #1;
    check("reset_out", output_data, '0);
    check("reset_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: no symbol edge, output must stay zero.
    cur_tag = "idle_after_reset";
    for (int k = 0; k < 6; k++) exp_q.push_back('0);
    drain();

    run_phase("mode1", 3'd1, 12, 12, 2, 32'hA5A5A5A5, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 1);
    run_phase("mode1_new", 3'd1, 12, 12, 1, 32'h11111111, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 1);
    run_phase("mode2", 3'd2, 6, 12, 3, 32'hA5A5A5A5, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 1);
    run_phase("mode3_mid", 3'd3, 4, 12, 2, 32'hA5A5A5A5, 32'hABABABAB, 32'hF0F0F0F0, 1,
              32'h12345678, 1);
    run_phase("mode0", 3'd0, 4, 12, 2, 32'hA5A5A5A5, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 1);
    check("mode0_state", 32'(state_dbg), 32'd0);
    run_phase("mode7", 3'd7, 4, 12, 1, 32'h5A5A5A5A, 32'h1, 32'h2, 0, '0, 1);
    run_phase("sw0_mode3", 3'd3, 0, 12, 2, 32'hCAFEF00D, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 1);
    run_phase("sw1_mode3", 3'd3, 1, 12, 2, 32'hA5A5A5A5, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 1);
    run_phase("sw1_mode2", 3'd2, 1, 10, 1, 32'h0000AAAA, 32'h5555FFFF, 32'h0, 0, '0, 1);
    run_phase("sw20_mode3", 3'd3, 20, 12, 3, 32'hA5A5A5A5, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 1);

    // Random patterns.
    for (int r = 0; r < 4; r++) begin
      run_phase("random", 3'($urandom_range(0, 3)), CW'($urandom_range(0, 5)),
                2 * $urandom_range(4, 9), 2, $urandom, $urandom, $urandom, 0, '0, 1);
    end

    // Asynchronous reset in the middle of a mode-3 rotation.
    run_phase("pre_reset", 3'd3, 4, 12, 1, 32'hA5A5A5A5, 32'hABABABAB, 32'hF0F0F0F0, 0, '0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_out", output_data, '0);
    check("async_reset_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    symbol_clk = 1'b0;
    cur_tag = "post_reset_idle";
    for (int k = 0; k < 8; k++) exp_q.push_back('0);
    drain();
    check("post_reset_state", 32'(state_dbg), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mux_fsm.md
Name: data_mux_fsm

Overview:
- Time-division multiplexer that merges up to three 32-bit data streams onto one output bus.
- Streams are captured once per symbol period, marked by rising edges of symbol_clk.
- Within the symbol period, the output steps through the active streams, changing every switch_clk_cycles clk cycles.
- Sits between the parallel stream sources and the serial symbol framer; runs entirely in the clk domain.

Parameters:
- DATA_W, 32, width of each stream and of output_data
- CNT_W, 32, width of switch_clk_cycles and of the internal slot counter

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- symbol_clk  in  1  symbol strobe, treated as data sampled by clk; its rising edge starts a symbol
- mode  in  3  1 = DS1 only; 2 = DS1/DS2 alternate; 3 = DS1/DS2/DS3 rotate; 0 and 4-7 = output zero
- switch_clk_cycles  in  CNT_W  clk cycles each stream is held on the output
- DS1  in  DATA_W  stream 1
- DS2  in  DATA_W  stream 2
- DS3  in  DATA_W  stream 3
- output_data  out  DATA_W  registered muxed output

Behaviour:
- Reset (rst=0, asynchronous): output_data=0, state=IDLE, counter=0, captured streams=0, captured mode=0, synchronizer/edge flops=0.
- Edge detection: symbol_clk passes through a 2-flop synchronizer. sym_edge = s2 & ~s3, where s3 is s2 delayed one cycle.
- On sym_edge:
  - capture DS1/DS2/DS3, mode and switch_clk_cycles into shadow registers;
  - clear the counter;
  - move to S_DS1.
- Inputs are used only through the shadow registers, so mid-symbol changes on DS*/mode/switch_clk_cycles take effect only at the next symbol edge.
- State machine: IDLE, S_DS1, S_DS2, S_DS3.
  - IDLE: output 0. Left only on sym_edge.
  - S_DS1 -> S_DS2 when counter == cap_switch-1 and cap_mode is 2 or 3.
  - S_DS2 -> S_DS1 when counter == cap_switch-1 and cap_mode == 2.
  - S_DS2 -> S_DS3 when counter == cap_switch-1 and cap_mode == 3.
  - S_DS3 -> S_DS1 when counter == cap_switch-1.
  - Counter clears on every state change; otherwise it increments and saturates at its maximum value.
- cap_mode 1: stay in S_DS1 for the whole symbol.
- cap_mode 0 or 4-7: state goes to IDLE on sym_edge; output 0.
- cap_switch = 0 or 1:
  - 0: no switching; hold S_DS1.
  - 1: change stream every cycle.
- sym_edge during mid-rotation has priority over the counter: it restarts at S_DS1 on the same edge.
- Output: output_data is registered from the next state's captured stream. It shows the new DS1 on the same clk edge that captures it, i.e. the 3rd clk rising edge after symbol_clk rises (setup met).
- Symbol period not a multiple of switch_clk_cycles × streams: rotation is simply truncated by the next sym_edge.

Optional Feature:
- Macro: DATA_MUX_SYNC_BYPASS_EN.
- Defined: synchronizer removed; s3 = registered symbol_clk and sym_edge = symbol_clk & ~s3. Latency is 1 clk edge. For symbol_clk already generated synchronously to clk.
- Undefined: 2-flop synchronizer as above, latency 3.

Decomposition:
- Package data_mux_pkg:
  - state enum {IDLE, S_DS1, S_DS2, S_DS3};
  - mode constants MODE_DS1=3'd1, MODE_DS12=3'd2, MODE_DS123=3'd3;
  - DATA_W/CNT_W default constants.
- Sub-module symbol_edge_detect: synchronizer plus rising-edge pulse, including the bypass macro handling.
- Top holds the shadow registers, counter, FSM and output register.

Test Plan:
- Reset: rst=0 mid-rotation with mode=3 -> output_data=0 immediately (asynchronous), state IDLE; after release, output stays 0 until the next symbol_clk rise.
- Mode 1: switch=12, DS1=A5A5A5A5 -> output A5A5A5A5 for the full 12-cycle symbol. New DS1=11111111 applied at the next edge -> output 11111111 three cycles after that edge.
- Mode 2: switch=6, 120-unit symbol (12 clk cycles), DS1=A5A5A5A5, DS2=ABABABAB -> 6 cycles A5A5A5A5 then 6 cycles ABABABAB, repeating per symbol.
- Mode 3: switch=4, DS3=F0F0F0F0 -> 4 cycles each of A5A5A5A5, ABABABAB, F0F0F0F0. Changing DS2 mid-symbol has no effect until the next edge.
- Boundaries:
  - mode=0 -> output 0;
  - switch=0 with mode=3 -> DS1 held all symbol;
  - switch=1 -> stream changes every cycle;
  - switch=20 > 12-cycle symbol -> rotation restarts at DS1 on each edge, DS2 never appears.
- Macro: with DATA_MUX_SYNC_BYPASS_EN defined -> new DS1 appears 1 clk edge after symbol_clk rises.
